qspi_dispatcher: RTL and testbench

Parametrised successor to the single-configuration QSPI parallelizer. Receives a nibble-serial QSPI stream and assembles it into `ENCRYPTER_WIDTH`-bit words. A key word is broadcast to all encrypters; data words are dispatched round-robin with an incrementing key rotation. New behaviour over the previous generation:
- fully synchronous, single-edge operation;
- explicit nibble handshake;
- zero-padded flush of partial packets;
- atomic key commit;
- optional skip-busy dispatch.

---
 rtl/qspi_dispatcher.sv | 194 +++++++++++++++++++
 tb/tb_qspi_dispatcher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_dispatcher.sv
// qspi_dispatcher: assembles a nibble-serial QSPI stream into words, broadcasts keys and dispatches data round-robin.
// Define DISPATCH_SKIP_BUSY_EN to dispatch to the first ready channel at or after the pointer instead of waiting on it.
module qspi_dispatcher #(
    parameter int NUM_ENCRYPTERS = 4,
    parameter int ENCRYPTER_WIDTH = 32,
    parameter int ROT_MOD = 32,
    localparam int NIBBLES = ENCRYPTER_WIDTH / 4,
    localparam int ROT_W = (ROT_MOD > 1) ? $clog2(ROT_MOD) : 1,
    localparam int IDX_W = $clog2(NUM_ENCRYPTERS),
    localparam int CNT_W = $clog2(NIBBLES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 qspi_data,
    input  logic                       qspi_sending,
    output logic                       qspi_ready,
    input  logic                       prog,
    output logic [ENCRYPTER_WIDTH-1:0] encrypters_data,
    output logic [ROT_W-1:0]           encrypters_key_rotation,
    output logic [NUM_ENCRYPTERS-1:0]  encrypters_program,
    output logic [NUM_ENCRYPTERS-1:0]  encrypters_data_ready,
    input  logic [NUM_ENCRYPTERS-1:0]  encrypters_ready,
    output logic [IDX_W-1:0]           dispatch_index
);
    typedef enum logic [2:0] {S_IDLE, S_KEY_RX, S_KEY_LOAD, S_KEY_WAIT, S_DATA_RX, S_DISPATCH} state_t;

    state_t                     r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [ENCRYPTER_WIDTH-1:0] r_shadow, w_shadow_nxt, r_key, w_key_nxt;
    logic [ENCRYPTER_WIDTH-1:0] r_packet, w_packet_nxt, r_data, w_data_nxt, w_word;
    logic [IDX_W-1:0]           r_ptr, w_ptr_nxt, w_sel;
    logic [ROT_W-1:0]           r_rot, w_rot_nxt, r_rot_out, w_rot_out_nxt;
    logic [NUM_ENCRYPTERS-1:0]  r_program, w_program_nxt, r_dready, w_dready_nxt;
    logic                       r_flush, w_flush_nxt, r_pending, w_pending_nxt, r_qspi_ready;
    logic                       w_found, w_go, w_last;

    // Nibbles land at fixed MSB-first positions so a short packet is already zero-padded.
    function automatic logic [ENCRYPTER_WIDTH-1:0] put(input logic [ENCRYPTER_WIDTH-1:0] v,
                                                       input logic [CNT_W-1:0] c, input logic [3:0] n);
        logic [ENCRYPTER_WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < NIBBLES; i++)
            if (c == CNT_W'(i)) r[ENCRYPTER_WIDTH-1-4*i -: 4] = n;
        return r;
    endfunction

`ifdef DISPATCH_SKIP_BUSY_EN
    logic [NUM_ENCRYPTERS-1:0] w_rr;
    logic [IDX_W:0]            w_idx;
    always_comb begin
        w_found = 1'b0;
        w_sel = r_ptr;
        w_idx = '0;
        w_rr = NUM_ENCRYPTERS'({encrypters_ready, encrypters_ready} >> r_ptr);
        for (int k = NUM_ENCRYPTERS - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_idx >= (IDX_W+1)'(NUM_ENCRYPTERS)) w_idx = w_idx - (IDX_W+1)'(NUM_ENCRYPTERS);
            if (w_rr[k]) begin
                w_found = 1'b1;
                w_sel = w_idx[IDX_W-1:0];
            end
        end
    end
`else
    always_comb begin
        w_found = encrypters_ready[r_ptr];
        w_sel = r_ptr;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt = r_cnt;
        w_shadow_nxt = r_shadow;
        w_key_nxt = r_key;
        w_packet_nxt = r_packet;
        w_data_nxt = r_data;
        w_ptr_nxt = r_ptr;
        w_rot_nxt = r_rot;
        w_rot_out_nxt = r_rot_out;
        w_flush_nxt = r_flush;
        w_pending_nxt = r_pending;
        w_program_nxt = '0;
        w_dready_nxt = '0;
        w_word = r_packet;
        w_go = 1'b0;
        w_last = r_cnt == CNT_W'(NIBBLES - 1);
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (prog) begin
                    w_state_nxt = S_KEY_RX;
                    w_shadow_nxt = '0;
                end else if (qspi_sending) begin
                    w_state_nxt = S_DATA_RX;
                    w_packet_nxt = '0;
                end
            end
            S_KEY_RX: begin
                if (qspi_sending) begin
                    w_shadow_nxt = put(r_shadow, r_cnt, qspi_data);
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_state_nxt = w_last ? S_KEY_LOAD : S_KEY_RX;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_KEY_LOAD: begin
                w_key_nxt = r_shadow;
                w_data_nxt = r_shadow;
                w_program_nxt = '1;
                w_rot_nxt = '0;
                w_ptr_nxt = '0;
                w_state_nxt = S_KEY_WAIT;
            end
            S_KEY_WAIT: w_state_nxt = (&encrypters_ready) ? S_IDLE : S_KEY_WAIT;
            S_DATA_RX: begin
                if (qspi_sending) begin
                    w_packet_nxt = put(r_packet, r_cnt, qspi_data);
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if ((qspi_sending && w_last) || (!qspi_sending && r_cnt != '0)) begin
                    // Dispatch on the completing edge itself when the target is already free.
                    w_state_nxt = S_DISPATCH;
                    w_flush_nxt = !qspi_sending;
                    w_pending_nxt = 1'b1;
                    w_word = w_packet_nxt;
                    w_go = w_found;
                end else if (!qspi_sending) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DISPATCH: begin
                if (!r_pending || w_found) begin
                    w_go = r_pending;
                    w_pending_nxt = 1'b0;
                    w_state_nxt = (!r_flush && qspi_sending) ? S_DATA_RX : S_IDLE;
                    w_cnt_nxt = '0;
                    w_packet_nxt = (!r_flush && qspi_sending) ? '0 : r_packet;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_go) begin
            w_data_nxt = w_word;
            w_rot_out_nxt = r_rot;
            w_dready_nxt = {{(NUM_ENCRYPTERS-1){1'b0}}, 1'b1} << w_sel;
            w_ptr_nxt = (w_sel == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : w_sel + 1'b1;
            w_rot_nxt = (r_rot == ROT_W'(ROT_MOD - 1)) ? '0 : r_rot + 1'b1;
            w_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt <= '0;
            r_shadow <= '0;
            r_key <= '0;
            r_packet <= '0;
            r_data <= '0;
            r_ptr <= '0;
            r_rot <= '0;
            r_rot_out <= '0;
            r_flush <= 1'b0;
            r_pending <= 1'b0;
            r_program <= '0;
            r_dready <= '0;
            r_qspi_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_key <= w_key_nxt;
            r_packet <= w_packet_nxt;
            r_data <= w_data_nxt;
            r_ptr <= w_ptr_nxt;
            r_rot <= w_rot_nxt;
            r_rot_out <= w_rot_out_nxt;
            r_flush <= w_flush_nxt;
            r_pending <= w_pending_nxt;
            r_program <= w_program_nxt;
            r_dready <= w_dready_nxt;
            r_qspi_ready <= (w_state_nxt == S_KEY_RX) || (w_state_nxt == S_DATA_RX);
        end
    end

    assign qspi_ready = r_qspi_ready;
    assign encrypters_data = r_data;
    assign encrypters_key_rotation = r_rot_out;
    assign encrypters_program = r_program;
    assign encrypters_data_ready = r_dready;
    assign dispatch_index = r_ptr;
endmodule

// File: tb/tb_qspi_dispatcher.sv
// tb_qspi_dispatcher: directed vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_qspi_dispatcher;
    logic        clk, reset, qspi_sending, qspi_ready, prog;
    logic [3:0]  qspi_data, encrypters_program, encrypters_data_ready, encrypters_ready;
    logic [31:0] encrypters_data;
    logic [4:0]  encrypters_key_rotation;
    logic [1:0]  dispatch_index;

    int n_vec = 0, n_bad = 0;
    bit mon_en = 0, rnd_rdy = 0;

    typedef struct {
        bit key; logic [31:0] word; int n; bit keep; logic [3:0] rdy;
        logic [3:0] edr; logic [31:0] edata; logic [4:0] erot; logic [1:0] eidx; int eprog;
    } vec_t;
    typedef struct { logic [3:0] dr; logic [31:0] data; logic [4:0] rot; } exp_t;

    vec_t tv[10];
    exp_t exp_q[$];
    exp_t mon_e;

    qspi_dispatcher dut (
        .clk(clk), .reset(reset), .qspi_data(qspi_data), .qspi_sending(qspi_sending),
        .qspi_ready(qspi_ready), .prog(prog), .encrypters_data(encrypters_data),
        .encrypters_key_rotation(encrypters_key_rotation), .encrypters_program(encrypters_program),
        .encrypters_data_ready(encrypters_data_ready), .encrypters_ready(encrypters_ready),
        .dispatch_index(dispatch_index)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_qready"}, 64'(qspi_ready), 0);
        chk({tag, "_data"}, 64'(encrypters_data), 0);
        chk({tag, "_rot"}, 64'(encrypters_key_rotation), 0);
        chk({tag, "_program"}, 64'(encrypters_program), 0);
        chk({tag, "_dready"}, 64'(encrypters_data_ready), 0);
        chk({tag, "_index"}, 64'(dispatch_index), 0);
    endtask

    task automatic step();
        @(negedge clk);
        if (rnd_rdy) encrypters_ready = 4'($urandom_range(0, 15));
    endtask

    // Host side: presents nibble i until qspi_ready shows it was taken; caller is at a negedge.
    task automatic host_send(input bit key, input logic [31:0] w, input int n, input bit keep);
        int i, t;
        bit x;
        i = 0;
        t = 0;
        prog = key;
        qspi_sending = 1;
        qspi_data = w[31:28];
        while (i < n) begin
            x = qspi_ready;
            step();
            prog = 0;
            if (x) i++;
            qspi_data = (i < 8) ? 4'(w >> (28 - 4 * i)) : 4'h0;
            t++;
            if (t > 400) begin
                n_vec++;
                n_bad++;
                $display("FAIL host_send_timeout: got %0d nibbles accepted, want %0d", i, n);
                break;
            end
        end
        if (!keep) qspi_sending = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en && encrypters_data_ready != 4'h0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rnd_unexpected: got strobe %b, want none", encrypters_data_ready);
            end else begin
                mon_e = exp_q.pop_front();
                if (encrypters_data_ready !== mon_e.dr || encrypters_data !== mon_e.data ||
                    encrypters_key_rotation !== mon_e.rot) begin
                    n_bad++;
                    $display("FAIL rnd_dispatch: got ch=%b data=%h rot=%0d, want ch=%b data=%h rot=%0d",
                             encrypters_data_ready, encrypters_data, encrypters_key_rotation,
                             mon_e.dr, mon_e.data, mon_e.rot);
                end
            end
        end
    end

    initial begin
        vec_t v;
        exp_t e;
        int pc, t, n, m_ptr, m_rot;
        bit keep;
        logic [31:0] w, full;
        tv[0] = '{1'b1, 32'hDEADBEEF, 8, 1'b0, 4'hF, 4'h0, 32'hDEADBEEF, 5'd0, 2'd0, 1};
        tv[1] = '{1'b0, 32'h11111111, 8, 1'b1, 4'hF, 4'h1, 32'h11111111, 5'd0, 2'd1, 0};
        tv[2] = '{1'b0, 32'h22222222, 8, 1'b1, 4'hF, 4'h2, 32'h22222222, 5'd1, 2'd2, 0};
        tv[3] = '{1'b0, 32'h33333333, 8, 1'b0, 4'hF, 4'h4, 32'h33333333, 5'd2, 2'd3, 0};
        tv[4] = '{1'b1, 32'h01234567, 8, 1'b0, 4'hF, 4'h0, 32'h01234567, 5'd0, 2'd0, 1};
        tv[5] = '{1'b0, 32'hABCDEF12, 3, 1'b0, 4'hF, 4'h1, 32'hABC00000, 5'd0, 2'd1, 0};
        tv[6] = '{1'b1, 32'hCAFEF00D, 5, 1'b0, 4'hF, 4'h0, 32'hABC00000, 5'd0, 2'd1, 0};
        tv[7] = '{1'b0, 32'h44444444, 8, 1'b0, 4'hF, 4'h2, 32'h44444444, 5'd1, 2'd2, 0};
        tv[8] = '{1'b1, 32'h12345678, 8, 1'b0, 4'hF, 4'h0, 32'h12345678, 5'd0, 2'd0, 1};
        tv[9] = '{1'b0, 32'h55555555, 8, 1'b0, 4'hF, 4'h1, 32'h55555555, 5'd0, 2'd1, 0};

        reset = 0;
        prog = 0;
        qspi_sending = 0;
        qspi_data = 0;
        encrypters_ready = 4'hF;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            v = tv[r];
            encrypters_ready = v.rdy;
            host_send(v.key, v.word, v.n, v.keep);
            if (v.key) begin
                pc = 0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (encrypters_program == 4'hF) pc++;
                    else if (encrypters_program != 4'h0) pc += 100;
                end
                chk($sformatf("row%0d_program_pulses", r), 64'(pc), 64'(v.eprog));
                chk($sformatf("row%0d_key_bus", r), 64'(encrypters_data), 64'(v.edata));
                chk($sformatf("row%0d_index", r), 64'(dispatch_index), 64'(v.eidx));
            end else begin
                if (v.n < 8) @(negedge clk);
                chk($sformatf("row%0d_strobe", r), 64'(encrypters_data_ready), 64'(v.edr));
                chk($sformatf("row%0d_data", r), 64'(encrypters_data), 64'(v.edata));
                chk($sformatf("row%0d_rot", r), 64'(encrypters_key_rotation), 64'(v.erot));
                chk($sformatf("row%0d_index", r), 64'(dispatch_index), 64'(v.eidx));
            end
            if (!v.keep) repeat (2) @(negedge clk);
        end

        // Pointer sits at 1 with channel 1 busy.
        encrypters_ready = 4'b1101;
        host_send(0, 32'h66666666, 8, 0);
`ifdef DISPATCH_SKIP_BUSY_EN
        chk("busy_skip_strobe", 64'(encrypters_data_ready), 64'h4);
        chk("busy_skip_index", 64'(dispatch_index), 3);
        chk("busy_skip_rot", 64'(encrypters_key_rotation), 1);
        encrypters_ready = 4'hF;
`else
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("busy_wait%0d_strobe", c), 64'(encrypters_data_ready), 0);
            chk($sformatf("busy_wait%0d_qready", c), 64'(qspi_ready), 0);
            @(negedge clk);
        end
        encrypters_ready = 4'hF;
        @(negedge clk);
        chk("busy_release_strobe", 64'(encrypters_data_ready), 64'h2);
        chk("busy_release_data", 64'(encrypters_data), 64'h66666666);
        chk("busy_release_rot", 64'(encrypters_key_rotation), 1);
        chk("busy_release_index", 64'(dispatch_index), 2);
`endif
        repeat (2) @(negedge clk);

        host_send(0, 32'h77777777, 4, 1);
        reset = 0;
        @(negedge clk);
        chk_zero("midword_reset");
        reset = 1;
        qspi_sending = 0;
        repeat (2) @(negedge clk);
        host_send(0, 32'h88888888, 8, 0);
        chk("post_reset_strobe", 64'(encrypters_data_ready), 64'h1);
        chk("post_reset_data", 64'(encrypters_data), 64'h88888888);
        chk("post_reset_rot", 64'(encrypters_key_rotation), 0);
        chk("post_reset_index", 64'(dispatch_index), 1);
        repeat (2) @(negedge clk);

        // Random words against a transaction-level model: strict order, rotation mod 32, zero-padded tails.
        m_ptr = 1;
        m_rot = 1;
        full = 32'hFFFFFFFF;
        mon_en = 1;
`ifndef DISPATCH_SKIP_BUSY_EN
        rnd_rdy = 1;
`endif
        for (int k = 0; k < 60; k++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            w = $urandom;
            keep = (n == 8) && ($urandom_range(0, 1) == 1) && (k < 59);
            e.dr = 4'(1 << m_ptr);
            e.data = w & ~(full >> (4 * n));
            e.rot = 5'(m_rot);
            exp_q.push_back(e);
            m_ptr = (m_ptr + 1) % 4;
            m_rot = (m_rot + 1) % 32;
            host_send(0, w, n, keep);
            if (!keep) repeat ($urandom_range(1, 3)) step();
        end
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        repeat (2) step();
        chk("rnd_drain_left", 64'(exp_q.size()), 0);
        mon_en = 0;
        rnd_rdy = 0;
        encrypters_ready = 4'hF;
        @(negedge clk);
        chk("rnd_final_index", 64'(dispatch_index), 64'(m_ptr));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
